// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write path.
package regfile_pkg;

   localparam int DATA_WIDTH    = 32;
   localparam int NUM_REGISTERS = 32;
   localparam int REG_IDX_W     = $clog2(NUM_REGISTERS);

   typedef logic [REG_IDX_W-1:0]  reg_idx_t;
   typedef logic [DATA_WIDTH-1:0] word_t;

   typedef struct packed {
      reg_idx_t idx;
      word_t    data;
   } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshake plus register-file write port bundle.
// master: producers and the register file; slave: the arbiter.
interface regfile_write_arbiter_if
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3
) ();

   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0][REG_IDX_W-1:0]  req_reg;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]                 req_ready;

   reg_idx_t rf_write_register;
   word_t    rf_write_data;
   logic     rf_write_activate;
   logic     rf_write_done;

   modport master (
      output req_valid, req_reg, req_data, rf_write_done,
      input  req_ready, rf_write_register, rf_write_data, rf_write_activate
   );

   modport slave (
      input  req_valid, req_reg, req_data, rf_write_done,
      output req_ready, rf_write_register, rf_write_data, rf_write_activate
   );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// One-hot grant selection among NUM_REQ requesters.
// Default: round-robin, search starts after the last granted index.
// REGFILE_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins, no pointer.
module rr_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] gnt
);

`ifdef REGFILE_ARB_FIXED_PRIO_EN

   logic unused_arb;
   assign unused_arb = clk ^ rst_n ^ advance;

   // isolate the lowest set request bit
   always_comb begin
      gnt = req & (~req + NUM_REQ'(1));
   end

`else

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] cand;
   int                 sh;

   // walk from the farthest candidate to the nearest so the nearest valid one wins
   always_comb begin
      gnt  = '0;
      cand = '0;
      sh   = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         sh   = (int'(ptr_q) + k) % NUM_REQ;
         cand = NUM_REQ'(1) << sh;
         if ((req & cand) != '0) gnt = cand;
      end
   end

   // pointer moves to the granted index only when the grant is taken
   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) ptr_d = PTR_W'(i);
         end
      end
   end

   // reset to the last index so requester 0 is searched first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= PTR_W'(NUM_REQ - 1);
      else        ptr_q <= ptr_d;
   end

`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NUM_REQ producers through
// one registered output stage, and tracks pending writes per register.
// Arbitration mode selected by REGFILE_ARB_FIXED_PRIO_EN (see rr_arbiter).
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   regfile_write_arbiter_if.slave   bus,
   input  logic                     rsv_valid,
   input  reg_idx_t                 rsv_reg,
   input  reg_idx_t                 query_reg_1,
   input  reg_idx_t                 query_reg_2,
   output logic                     busy_1,
   output logic                     busy_2,
   output logic [NUM_REGISTERS-1:0] busy_vec
);

   logic                     out_vld_q, out_vld_d;
   wr_req_t                  out_q, out_d;
   wr_req_t                  sel;
   logic                     drain, free, accept;
   logic [NUM_REQ-1:0]       gnt;
   logic [NUM_REGISTERS-1:0] busy_q, busy_d;

   assign drain = out_vld_q & bus.rf_write_done;
   assign free  = ~out_vld_q | drain;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus.req_valid),
      .advance (accept),
      .gnt     (gnt)
   );

   // no grant while the stage is blocked or while in reset
   assign bus.req_ready = gnt & {NUM_REQ{free & rst_n}};
   assign accept        = |bus.req_ready;

   // mux the granted request's index and data
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.req_ready[i]) begin
            sel.idx  = bus.req_reg[i];
            sel.data = bus.req_data[i];
         end
      end
   end

   // output stage: drain on done, refill on accept; x0 writes are swallowed
   always_comb begin
      out_vld_d = out_vld_q & ~drain;
      out_d     = out_q;
      if (accept && sel.idx != '0) begin
         out_vld_d = 1'b1;
         out_d     = sel;
      end
   end

   // output stage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q <= 1'b0;
         out_q     <= '0;
      end else begin
         out_vld_q <= out_vld_d;
         out_q     <= out_d;
      end
   end

   assign bus.rf_write_activate = out_vld_q;
   assign bus.rf_write_register = out_q.idx;
   assign bus.rf_write_data     = out_q.data;

   // scoreboard: commit clears, reservation sets and wins a same-edge tie
   always_comb begin
      busy_d = busy_q;
      if (drain)     busy_d[out_q.idx] = 1'b0;
      if (rsv_valid) busy_d[rsv_reg]   = 1'b1;
      busy_d[0] = 1'b0;
   end

   // scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy_vec = busy_q;
   assign busy_1   = busy_q[query_reg_1];
   assign busy_2   = busy_q[query_reg_2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, corner sequences, random vs model.
module tb_regfile_write_arbiter;
   import regfile_pkg::*;

   localparam int NR = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rsv_valid;
   logic [4:0] rsv_reg, query_reg_1, query_reg_2;
   logic busy_1, busy_2;
   logic [31:0] busy_vec;

   int checks = 0;
   int failures = 0;

   regfile_write_arbiter_if #(.NUM_REQ(NR)) bus ();

   regfile_write_arbiter #(.NUM_REQ(NR)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .rsv_valid   (rsv_valid),
      .rsv_reg     (rsv_reg),
      .query_reg_1 (query_reg_1),
      .query_reg_2 (query_reg_2),
      .busy_1      (busy_1),
      .busy_2      (busy_2),
      .busy_vec    (busy_vec)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  valid;
      logic        done;
      logic [2:0]  ready;
      logic        act;
      logic [4:0]  wreg;
      logic [31:0] data;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t row(logic [2:0] v, logic d, logic [2:0] rdy, logic a,
                                logic [4:0] r, logic [31:0] dt);
      vec_t x;
      x.valid = v; x.done = d; x.ready = rdy; x.act = a; x.wreg = r; x.data = dt;
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_valid = '0;
      bus.rf_write_done = 1'b1;
      rsv_valid = 1'b0;
      rsv_reg = '0;
      query_reg_1 = '0;
      query_reg_2 = '0;
   endtask

   task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
      bus.req_reg[i]  = r;
      bus.req_data[i] = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // reference model state
   bit        m_vld;
   bit [4:0]  m_reg;
   bit [31:0] m_data;
   bit [31:0] m_busy;
   int        m_last;

   initial begin
      clear_inputs();
      for (int i = 0; i < NR; i++) set_req(i, 5'd0, 32'd0);

      // ---- reset state, with requests present during reset ----
      bus.req_valid = 3'b111;
      #3;
      chk("rst_ready", bus.req_ready, 3'b000);
      chk("rst_act", bus.rf_write_activate, 1'b0);
      chk("rst_reg", bus.rf_write_register, 5'd0);
      chk("rst_data", bus.rf_write_data, 32'd0);
      chk("rst_busy", busy_vec, 32'd0);
      do_reset();

      // ---- table: single write, contention, stall ----
      set_req(0, 5'd5, 32'hDEAD_BEEF);
      set_req(1, 5'd6, 32'h1111_1111);
      set_req(2, 5'd7, 32'h2222_2222);
      tbl.push_back(row(3'b001, 1, 3'b001, 0, 5'd0, 32'h0));
      tbl.push_back(row(3'b000, 1, 3'b000, 1, 5'd5, 32'hDEAD_BEEF));
      tbl.push_back(row(3'b000, 1, 3'b000, 0, 5'd0, 32'h0));
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      tbl.push_back(row(3'b111, 1, 3'b001, 0, 5'd0, 32'h0));
      for (int k = 0; k < 4; k++)
         tbl.push_back(row(3'b111, 1, 3'b001, 1, 5'd5, 32'hDEAD_BEEF));
      for (int k = 0; k < 3; k++)
         tbl.push_back(row(3'b010, 0, 3'b000, 1, 5'd5, 32'hDEAD_BEEF));
      tbl.push_back(row(3'b010, 1, 3'b010, 1, 5'd5, 32'hDEAD_BEEF));
`else
      tbl.push_back(row(3'b111, 1, 3'b010, 0, 5'd0, 32'h0));
      tbl.push_back(row(3'b111, 1, 3'b100, 1, 5'd6, 32'h1111_1111));
      tbl.push_back(row(3'b111, 1, 3'b001, 1, 5'd7, 32'h2222_2222));
      tbl.push_back(row(3'b111, 1, 3'b010, 1, 5'd5, 32'hDEAD_BEEF));
      tbl.push_back(row(3'b111, 1, 3'b100, 1, 5'd6, 32'h1111_1111));
      for (int k = 0; k < 3; k++)
         tbl.push_back(row(3'b010, 0, 3'b000, 1, 5'd7, 32'h2222_2222));
      tbl.push_back(row(3'b010, 1, 3'b010, 1, 5'd7, 32'h2222_2222));
`endif
      tbl.push_back(row(3'b000, 1, 3'b000, 1, 5'd6, 32'h1111_1111));
      tbl.push_back(row(3'b000, 1, 3'b000, 0, 5'd0, 32'h0));

      foreach (tbl[r]) begin
         bus.req_valid = tbl[r].valid;
         bus.rf_write_done = tbl[r].done;
         #2;
         chk($sformatf("tbl%0d_ready", r), bus.req_ready, tbl[r].ready);
         chk($sformatf("tbl%0d_act", r), bus.rf_write_activate, tbl[r].act);
         if (tbl[r].act) begin
            chk($sformatf("tbl%0d_reg", r), bus.rf_write_register, tbl[r].wreg);
            chk($sformatf("tbl%0d_data", r), bus.rf_write_data, tbl[r].data);
         end
         tick();
      end
      bus.req_valid = '0;

      // ---- scoreboard: set, set-wins-over-clear, clear ----
      query_reg_1 = 5'd7;
      query_reg_2 = 5'd7;
      rsv_valid = 1'b1; rsv_reg = 5'd7;
      #2;
      chk("sb_no_bypass", busy_1, 1'b0);
      tick();
      rsv_valid = 1'b0;
      #2;
      chk("sb_set_b1", busy_1, 1'b1);
      chk("sb_set_b2", busy_2, 1'b1);
      set_req(0, 5'd7, 32'h0000_0077);
      bus.req_valid = 3'b001;
      tick();
      bus.req_valid = '0;
      rsv_valid = 1'b1; rsv_reg = 5'd7;
      #2;
      chk("sb_pending_act", bus.rf_write_activate, 1'b1);
      tick();
      rsv_valid = 1'b0;
      #2;
      chk("sb_set_wins", busy_1, 1'b1);
      bus.req_valid = 3'b001;
      tick();
      bus.req_valid = '0;
      tick();
      #1;
      chk("sb_cleared", busy_1, 1'b0);
      chk("sb_vec_clear", busy_vec, 32'd0);

      // ---- x0 write: handshake only ----
      set_req(2, 5'd0, 32'h0000_1234);
      bus.req_valid = 3'b100;
      #2;
      chk("x0_ready", bus.req_ready, 3'b100);
      tick();
      bus.req_valid = '0;
      #2;
      chk("x0_ready_drop", bus.req_ready, 3'b000);
      chk("x0_act0", bus.rf_write_activate, 1'b0);
      rsv_valid = 1'b1; rsv_reg = 5'd0;
      tick();
      rsv_valid = 1'b0;
      #2;
      chk("x0_act1", bus.rf_write_activate, 1'b0);
      chk("x0_busy0", busy_vec, 32'd0);

      // ---- reset mid-write with busy x8..x11 ----
      for (int r = 8; r < 12; r++) begin
         rsv_valid = 1'b1; rsv_reg = 5'(r);
         tick();
      end
      rsv_valid = 1'b0;
      set_req(0, 5'd9, 32'hCAFE_0009);
      bus.req_valid = 3'b001;
      bus.rf_write_done = 1'b0;
      tick();
      #1;
      chk("mid_busy", busy_vec, 32'h0000_0F00);
      chk("mid_act", bus.rf_write_activate, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_act", bus.rf_write_activate, 1'b0);
      chk("mid_rst_reg", bus.rf_write_register, 5'd0);
      chk("mid_rst_data", bus.rf_write_data, 32'd0);
      chk("mid_rst_busy", busy_vec, 32'd0);
      chk("mid_rst_ready", bus.req_ready, 3'b000);
      bus.req_valid = '0;
      bus.rf_write_done = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk($sformatf("post_rst_act%0d", k), bus.rf_write_activate, 1'b0);
         tick();
      end

      // ---- randomized traffic against the behavioural model ----
      do_reset();
      m_vld = 0; m_reg = 0; m_data = 0; m_busy = 0; m_last = NR - 1;
      for (int c = 0; c < 400; c++) begin
         int winner;
         bit free;
         logic [2:0] exp_ready;
         bus.req_valid = 3'($urandom);
         for (int i = 0; i < NR; i++)
            set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
         bus.rf_write_done = ($urandom_range(0, 3) != 0);
         rsv_valid = $urandom_range(0, 1);
         rsv_reg = 5'($urandom);
         query_reg_1 = 5'($urandom);
         query_reg_2 = 5'($urandom);
         #2;
         free = !m_vld || bus.rf_write_done;
         winner = -1;
         if (free) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            for (int i = NR - 1; i >= 0; i--)
               if (bus.req_valid[i]) winner = i;
`else
            for (int k = NR; k >= 1; k--)
               if (bus.req_valid[(m_last + k) % NR]) winner = (m_last + k) % NR;
`endif
         end
         exp_ready = (winner >= 0) ? 3'(1 << winner) : 3'b000;
         chk("rnd_ready", bus.req_ready, exp_ready);
         chk("rnd_act", bus.rf_write_activate, m_vld);
         if (m_vld) begin
            chk("rnd_reg", bus.rf_write_register, m_reg);
            chk("rnd_data", bus.rf_write_data, m_data);
         end
         chk("rnd_busy_1", busy_1, m_busy[query_reg_1]);
         chk("rnd_busy_2", busy_2, m_busy[query_reg_2]);
         chk("rnd_busy_vec", busy_vec, m_busy);
         // model update for the coming edge
         if (m_vld && bus.rf_write_done) begin
            m_busy[m_reg] = 1'b0;
            m_vld = 0;
         end
         if (winner >= 0) begin
            m_last = winner;
            if (bus.req_reg[winner] != 0) begin
               m_vld = 1;
               m_reg = bus.req_reg[winner];
               m_data = bus.req_data[winner];
            end
         end
         if (rsv_valid && rsv_reg != 0) m_busy[rsv_reg] = 1'b1;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
